gate_checker: RTL
=================

# gate_checker

Self-checking stimulus/response block for a seven-output two-input logic-gate unit (AND, OR, NOT-a, NAND, NOR, XOR, XNOR).
- On `start` it drives the unit's `a`/`b` inputs through all four input combinations.
- After a programmable settle time it samples the unit's outputs for each combination and compares them with the expected truth table.
- It reports a sticky per-gate failure mask and a pass flag.
- It sits on the test/BIST side of the gate unit: its outputs feed the unit's inputs and the unit's outputs come back to it.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling. Legal range 1..255; 0 is illegal.

Ports (name, direction, width, meaning):
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: requests a test run; sampled only in IDLE.
- `a_drv` output 1: drives the gate unit input `a`.
- `b_drv` output 1: drives the gate unit input `b`.
- `gate_in` input 7: gate unit outputs, bit order [6]=and, [5]=or, [4]=not, [3]=nand, [2]=nor, [1]=xor, [0]=xnor.
- `busy` output 1: high from the cycle after start acceptance until the DONE cycle inclusive.
- `done` output 1: one-cycle pulse at the end of a run.
- `pass` output 1: 1 iff `fail_mask`==0 at the end of the last run.
- `fail_mask` output 7: sticky per-gate mismatch flags, same bit order as `gate_in`.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE. Internal registers: `vec[1:0]` and a settle counter `cnt` sized $clog2(SETTLE_CYCLES+1).
- Vector order is 00, 01, 10, 11, with `a_drv`=`vec[1]` and `b_drv`=`vec[0]`, both registered.
- IDLE:
  - `start`=1 at an edge → go to DRIVE, `vec`=0, `cnt`=0, `fail_mask`=0, `pass`=0.
  - Otherwise stay in IDLE. `a_drv`/`b_drv` are 0.
- DRIVE:
  - `cnt` increments each cycle.
  - At the edge where `cnt`==SETTLE_CYCLES-1 → go to SAMPLE.
- SAMPLE, on the edge leaving it:
  - Compute the expected vector E = {a&b, a|b, ~a, ~(a&b), ~(a|b), a^b, ~(a^b)} from the current `vec`.
  - Update `fail_mask` <= `fail_mask` | (`gate_in` ^ E).
  - If `vec`==3 → go to DONE. Otherwise `vec`++, `cnt`=0 → go to DRIVE.
- DONE:
  - `done`=1 and `busy`=1 for exactly one cycle.
  - `pass` is registered at DONE entry as (final `fail_mask`==0), so it is valid while `done`=1.
  - Next state is IDLE.
- `pass` and `fail_mask` hold their values after DONE until the next start is accepted.
- `start` outside IDLE is ignored. No queuing.
- `start` held high continuously gives back-to-back runs, with one IDLE cycle between DONE and the next DRIVE.
- `gate_in` is sampled only in SAMPLE. Its value in any other state is don't-care.

## Timing
- Reset values: state=IDLE, `a_drv`=0, `b_drv`=0, `busy`=0, `done`=0, `pass`=0, `fail_mask`=0, `vec`=0, `cnt`=0.
- Cycle numbering: cycle 0 is the accepting edge.
- Vector k (k=0..3) is on `a_drv`/`b_drv` during cycles k·(S+1)+1 through (k+1)·(S+1), where S=SETTLE_CYCLES. Its last cycle is the SAMPLE cycle.
- `done` is high in cycle 4(S+1)+1. With S=2 this is cycle 13.
- Total run length is 4(S+1)+1 cycles. `busy` is high for all of them.
- The gate unit path from `a_drv`/`b_drv` to `gate_in` must settle within S cycles.
- Reset asserted mid-run:
  - All outputs return to reset values immediately (asynchronously).
  - The run is aborted and no `done` pulse is produced.
  - After `rst_n` deasserts, a new `start` is required.

## Test plan
- Correct gate unit, S=2, single `start` pulse → `a_drv`/`b_drv` show 00,01,10,11 for 3 cycles each; `done` in cycle 13; `pass`=1; `fail_mask`=7'b0000000.
- `xnor` output stuck at 0 → `done` in cycle 13; `pass`=0; `fail_mask`=7'b0000001.
- `nand` and `nor` outputs swapped → `fail_mask`=7'b0001100 (mismatches at vectors 01 and 10); `pass`=0.
- `start` pulsed again in cycles 3 and 8 of a run → ignored; `done` is still at cycle 13; exactly one `done` pulse.
- `rst_n` low in cycle 6 with an `and` fault present:
  - Immediately `busy`=0, `fail_mask`=0, `a_drv`=`b_drv`=0, and no `done` pulse.
  - A new run on a correct unit then gives `pass`=1.
- `start` held high, S=1, correct unit → `done` in cycles 9 and 19; `busy`=0 only in cycle 10; `fail_mask` cleared at the second acceptance.

Source files
------------

// File: rtl/gate_checker.sv
// BIST-side checker for a seven-output two-input gate unit: walks a/b through
// 00,01,10,11, samples the unit after SETTLE_CYCLES and accumulates a sticky mismatch mask.
module gate_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_drv,
  output logic       b_drv,
  input  logic [6:0] gate_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] fail_mask
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("gate_checker: SETTLE_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [1:0]    vec;
  logic [CW-1:0] cnt;
  logic [6:0]    expected;
  logic [6:0]    mismatch;

  always_comb begin
    expected = {vec[1] & vec[0], vec[1] | vec[0], ~vec[1], ~(vec[1] & vec[0]),
                ~(vec[1] | vec[0]), vec[1] ^ vec[0], ~(vec[1] ^ vec[0])};
    mismatch = gate_in ^ expected;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DRIVE;
      DRIVE:   if (cnt == CNT_LAST) state_next = SAMPLE;
      SAMPLE:  state_next = (vec == 2'd3) ? DONE : DRIVE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // a_drv/b_drv are loaded together with vec so the unit sees each vector
  // from the first DRIVE cycle, and are cleared once the last vector is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec       <= 2'd0;
      cnt       <= '0;
      a_drv     <= 1'b0;
      b_drv     <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 7'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec       <= 2'd0;
            cnt       <= '0;
            a_drv     <= 1'b0;
            b_drv     <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= 7'd0;
          end
        end
        DRIVE: cnt <= cnt + CW'(1);
        SAMPLE: begin
          fail_mask <= fail_mask | mismatch;
          if (vec == 2'd3) begin
            pass  <= ((fail_mask | mismatch) == 7'd0);
            a_drv <= 1'b0;
            b_drv <= 1'b0;
          end else begin
            vec   <= vec + 2'd1;
            cnt   <= '0;
            a_drv <= (vec == 2'd1) || (vec == 2'd2);
            b_drv <= (vec == 2'd0) || (vec == 2'd2);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
